hostsystem_memory_arbiter: RTL and testbench

- Two-master arbiter in front of the 1024 x 64-bit single-port on-chip memory.
- Lets the Nios data master (m0) and a DMA/accelerator master (m1) share the memory's one Avalon-MM slave port.
- Arbitration is round-robin with a bounded hold count. One memory access is issued per clock.
- Read data returns with fixed 1-cycle latency (registered address, unregistered q), steered to the requester that issued the read.

---
 rtl/hostsystem_memory_arbiter.sv | 91 +++++++++
 tb/tb_hostsystem_memory_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hostsystem_memory_arbiter.sv
// hostsystem_memory_arbiter: round-robin, hold-limited two-master arbiter in front of a single-port 1-cycle-latency memory
module hostsystem_memory_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 64,
  parameter int BE_W     = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  output logic              mem_reset_req,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [15:0]       grant_count0,
  output logic [15:0]       grant_count1
);
  typedef enum logic {OWN0, OWN1} owner_t;
  localparam logic [3:0] HM = 4'(HOLD_MAX);
  owner_t owner_q, owner_d, rd_owner_q, rd_owner_d, gm;
  logic [3:0] hold_q, hold_d;
  logic rd_valid_q, rd_valid_d;
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic req0, req1, tie1, g0, g1, gnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= OWN1;
      hold_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      owner_q    <= owner_d;
      hold_q     <= hold_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end
  always_comb begin
    req0             = m0_read | m0_write;
    req1             = m1_read | m1_write;
    tie1             = (hold_q != 4'd0 && hold_q < HM) ? owner_q == OWN1 : owner_q == OWN0;
    g1               = ~reset & req1 & (~req0 | tie1);
    g0               = ~reset & req0 & ~g1;
    gnt              = g0 | g1;
    gm               = g1 ? OWN1 : OWN0;
    owner_d          = gnt ? gm : owner_q;
    hold_d           = !gnt ? hold_q : gm != owner_q ? 4'd1 : hold_q < HM ? hold_q + 4'd1 : hold_q;
    rd_valid_d       = g1 ? m1_read & ~m1_write : g0 & m0_read & ~m0_write;
    rd_owner_d       = gnt ? gm : rd_owner_q;
    cnt0_d           = cnt0_q + {15'd0, g0};
    cnt1_d           = cnt1_q + {15'd0, g1};
    m0_waitrequest   = req0 & ~g0;
    m1_waitrequest   = req1 & ~g1;
    m0_readdatavalid = rd_valid_q & (rd_owner_q == OWN0);
    m1_readdatavalid = rd_valid_q & (rd_owner_q == OWN1);
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
    mem_address      = g1 ? m1_address : m0_address;
    mem_byteenable   = g1 ? m1_byteenable : m0_byteenable;
    mem_writedata    = g1 ? m1_writedata : m0_writedata;
    mem_write        = g1 ? m1_write : g0 & m0_write;
    mem_chipselect   = gnt;
    mem_clken        = 1'b1;
    mem_reset_req    = reset;
    grant_count0     = cnt0_q;
    grant_count1     = cnt1_q;
  end
endmodule

// File: tb/tb_hostsystem_memory_arbiter.sv
// tb_hostsystem_memory_arbiter: table, directed and randomized model-checked bench for the memory arbiter
module tb_hostsystem_memory_arbiter;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int HM = 4;
  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, mem_writedata, mem_readdata;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic mem_chipselect, mem_write, mem_clken, mem_reset_req;
  logic [15:0] grant_count0, grant_count1;
  logic [DW-1:0] mem [0:1023] = '{default: '0};
  logic [DW-1:0] ref_mem [0:1023] = '{default: '0};
  logic [AW-1:0] addr_q = '0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic r0, w0, r1, w1;
    logic ew0, ew1, ecs, emw;
    logic [AW-1:0] eaddr;
  } vec_t;
  vec_t tbl [10];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write)
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      addr_q <= mem_address;
    end
  end
  assign mem_readdata = mem[addr_q];
  hostsystem_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_reset_req(mem_reset_req), .mem_readdata(mem_readdata),
    .grant_count0(grant_count0), .grant_count1(grant_count1)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {m0_read, m0_write, m1_read, m1_write} = '0;
    m0_address = '0; m1_address = '0;
    m0_byteenable = '0; m1_byteenable = '0;
    m0_writedata = '0; m1_writedata = '0;
  endtask
  task automatic pulse_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  initial begin
    int last, streak, win;
    logic [15:0] c0, c1;
    logic prv0, prv1, hold0, hold1, rq0, rq1, g0, g1, wr, rd;
    logic [1:0] rw;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] wd, pdata;
    tbl[0] = '{0,0,0,0, 0,0,0,0, 10'd1};
    tbl[1] = '{1,0,0,0, 0,0,1,0, 10'd1};
    tbl[2] = '{1,0,1,0, 0,1,1,0, 10'd1};
    tbl[3] = '{1,0,1,0, 0,1,1,0, 10'd1};
    tbl[4] = '{1,0,1,0, 0,1,1,0, 10'd1};
    tbl[5] = '{1,0,1,0, 1,0,1,0, 10'd2};
    tbl[6] = '{0,0,0,1, 0,0,1,1, 10'd2};
    tbl[7] = '{1,1,1,0, 1,0,1,0, 10'd2};
    tbl[8] = '{1,1,0,0, 0,0,1,1, 10'd1};
    tbl[9] = '{0,0,0,0, 0,0,0,0, 10'd1};
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdv0", m0_readdatavalid, 0);
    chk("rst_rdv1", m1_readdatavalid, 0);
    chk("rst_cnt0", grant_count0, 0);
    chk("rst_cnt1", grant_count1, 0);
    chk("rst_mem_reset_req", mem_reset_req, 1);
    chk("clken", mem_clken, 1);
    m0_read = 1'b1;
    #1;
    chk("rst_wait0_follows_req", m0_waitrequest, 1);
    chk("rst_no_cs", mem_chipselect, 0);
    m0_read = 1'b0;
    reset = 1'b0;
    #1;
    chk("rel_mem_reset_req", mem_reset_req, 0);
    step();
    // randomized phase against a transaction-level model
    last = 1; streak = 0; c0 = '0; c1 = '0;
    prv0 = 0; prv1 = 0; hold0 = 0; hold1 = 0; pdata = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold0) begin
        rw = 2'($urandom_range(0, 3));
        m0_read = rw[0]; m0_write = rw[1];
        m0_address = AW'($urandom_range(0, 15));
        m0_byteenable = BW'($urandom);
        m0_writedata = {$urandom, $urandom};
      end
      if (!hold1) begin
        rw = 2'($urandom_range(0, 3));
        m1_read = rw[0]; m1_write = rw[1];
        m1_address = AW'($urandom_range(0, 15));
        m1_byteenable = BW'($urandom);
        m1_writedata = {$urandom, $urandom};
      end
      #1;
      rq0 = m0_read | m0_write;
      rq1 = m1_read | m1_write;
      if (rq0 && rq1) win = (streak == 0) ? 0 : (streak < HM) ? last : 1 - last;
      else win = rq0 ? 0 : rq1 ? 1 : -1;
      g0 = (win == 0);
      g1 = (win == 1);
      chk("rnd_wait0", m0_waitrequest, rq0 & ~g0);
      chk("rnd_wait1", m1_waitrequest, rq1 & ~g1);
      chk("rnd_cs", mem_chipselect, g0 | g1);
      chk("rnd_rdv0", m0_readdatavalid, prv0);
      chk("rnd_rdv1", m1_readdatavalid, prv1);
      if (prv0) chk("rnd_rdata0", m0_readdata, pdata);
      if (prv1) chk("rnd_rdata1", m1_readdata, pdata);
      prv0 = 0; prv1 = 0;
      if (win >= 0) begin
        if (win == last) streak = (streak < HM) ? streak + 1 : streak;
        else begin last = win; streak = 1; end
        wr = g1 ? m1_write : m0_write;
        rd = g1 ? m1_read : m0_read;
        a = g1 ? m1_address : m0_address;
        be = g1 ? m1_byteenable : m0_byteenable;
        wd = g1 ? m1_writedata : m0_writedata;
        if (g0) c0++; else c1++;
        if (wr) begin
          for (int b = 0; b < BW; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        end else if (rd) begin
          pdata = ref_mem[a];
          prv0 = g0; prv1 = g1;
        end
      end
      hold0 = rq0 & ~g0;
      hold1 = rq1 & ~g1;
      step();
    end
    idle();
    #1;
    chk("rnd_cnt0", grant_count0, c0);
    chk("rnd_cnt1", grant_count1, c1);
    chk("rnd_last_rdv", m0_readdatavalid | m1_readdatavalid, prv0 | prv1);
    // table: arbitration pattern from reset, byteenable 0 so memory stays untouched
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      {m0_read, m0_write, m1_read, m1_write} = {tbl[i].r0, tbl[i].w0, tbl[i].r1, tbl[i].w1};
      m0_address = 10'd1; m1_address = 10'd2;
      m0_byteenable = '0; m1_byteenable = '0;
      #1;
      chk($sformatf("tbl%0d_wait0", i), m0_waitrequest, tbl[i].ew0);
      chk($sformatf("tbl%0d_wait1", i), m1_waitrequest, tbl[i].ew1);
      chk($sformatf("tbl%0d_cs", i), mem_chipselect, tbl[i].ecs);
      chk($sformatf("tbl%0d_mw", i), mem_write, tbl[i].emw);
      chk($sformatf("tbl%0d_addr", i), mem_address, tbl[i].eaddr);
      step();
    end
    // single master write then read
    idle();
    m0_write = 1; m0_address = 10'd5; m0_byteenable = 8'hFF; m0_writedata = 64'h1122334455667788;
    #1;
    chk("a_wait_wr", m0_waitrequest, 0);
    step();
    idle();
    m0_read = 1; m0_address = 10'd5;
    #1;
    chk("a_wait_rd", m0_waitrequest, 0);
    chk("a_no_rdv_for_write", m0_readdatavalid, 0);
    step();
    idle();
    #1;
    chk("a_rdv0", m0_readdatavalid, 1);
    chk("a_rdata0", m0_readdata, 64'h1122334455667788);
    chk("a_rdv1", m1_readdatavalid, 0);
    step();
    // byte lanes
    m1_write = 1; m1_address = 10'd7; m1_byteenable = 8'hFF; m1_writedata = '0;
    step();
    m1_byteenable = 8'h0F; m1_writedata = '1;
    #1;
    chk("b_wait_wr", m1_waitrequest, 0);
    step();
    idle();
    m1_read = 1; m1_address = 10'd7;
    step();
    idle();
    #1;
    chk("b_rdv1", m1_readdatavalid, 1);
    chk("b_rdata1", m1_readdata, 64'h00000000FFFFFFFF);
    chk("b_rdv0", m0_readdatavalid, 0);
    step();
    // read and write together is a write
    m0_read = 1; m0_write = 1; m0_address = 10'd3; m0_byteenable = 8'hFF; m0_writedata = 64'hA5;
    #1;
    chk("c_mem_write", mem_write, 1);
    step();
    idle();
    m0_read = 1; m0_address = 10'd3;
    #1;
    chk("c_no_rdv", m0_readdatavalid, 0);
    step();
    idle();
    #1;
    chk("c_rdv0", m0_readdatavalid, 1);
    chk("c_rdata0", m0_readdata, 64'hA5);
    step();
    // reset with a read in flight
    m0_read = 1; m0_address = 10'd5;
    step();
    idle();
    reset = 1'b1;
    #1;
    chk("d_rdv_dropped", m0_readdatavalid, 0);
    chk("d_cnt0", grant_count0, 0);
    chk("d_cnt1", grant_count1, 0);
    step();
    chk("d_rdv_dropped2", m0_readdatavalid | m1_readdatavalid, 0);
    reset = 1'b0;
    m0_read = 1; m0_address = 10'd5; m1_read = 1; m1_address = 10'd7;
    #1;
    chk("d_tie_wait0", m0_waitrequest, 0);
    chk("d_tie_wait1", m1_waitrequest, 1);
    step();
    idle();
    #1;
    chk("d_rdv0", m0_readdatavalid, 1);
    chk("d_rdata0", m0_readdata, 64'h1122334455667788);
    chk("d_cnt0_after", grant_count0, 1);
    step();
    // counter wrap
    pulse_reset();
    m1_read = 1; m1_address = 10'd0;
    repeat (65537) @(posedge clk);
    #1;
    idle();
    #1;
    chk("e_cnt1_wrap", grant_count1, 1);
    chk("e_cnt0", grant_count0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
